// File: rtl/skid_stage.sv
// skid_stage: two-entry elastic pipeline stage with a valid/ready handshake.
// The upstream ready is taken only from registered state, so it never depends
// combinationally on the downstream ready. The second entry (skid) catches the
// word that arrives in the same cycle the reader stalls.
module skid_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [N-1:0] m_data,
  input  logic         m_ready,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [N-1:0] main_reg;
  logic [N-1:0] skid_reg;
  logic         push;
  logic         pop;
  logic         load_main_from_in;
  logic         load_main_from_skid;
  logic         load_skid;

  // Handshake qualifiers; a transfer happens only on an edge where these are true
  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  // Ready is held low during reset and whenever both entries are occupied
  assign s_ready = (state != FULL) & reset;
  assign m_valid = (state != EMPTY);
  assign m_data  = main_reg;

  // Occupancy is a direct decode of the state
  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and data-register load decisions; flush overrides any handshake
  always_comb begin
    next_state          = state;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            next_state        = ONE;
            load_main_from_in = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            next_state = FULL;
            load_skid  = 1'b1;
          end else if (!push && pop) begin
            next_state = EMPTY;
          end else if (push && pop) begin
            next_state        = ONE;
            load_main_from_in = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            next_state          = ONE;
            load_main_from_skid = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Data registers load only on the listed transitions and otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main_from_in) begin
        main_reg <= s_data;
      end else if (load_main_from_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_skid_stage.sv
// tb_skid_stage: directed scenarios plus randomized traffic for skid_stage,
// checked against a queue model of a two-deep FIFO stage.
module tb_skid_stage;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush;
  logic         s_valid;
  logic [N-1:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [N-1:0] m_data;
  logic         m_ready;
  logic [1:0]   occupancy;

  int compare_count = 0;
  int mismatch_count = 0;

  // Reference model: the held words, oldest first
  logic [N-1:0] model_q[$];

  skid_stage #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .occupancy (occupancy)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                             input logic [N-1:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every output against what a two-deep FIFO would show now
  task automatic checkModel();
    checkOutput("m_valid", N'(m_valid), N'(model_q.size() > 0));
    checkOutput("occupancy", N'(occupancy), N'(model_q.size()));
    checkOutput("s_ready", N'(s_ready), N'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      checkOutput("m_data", m_data, model_q[0]);
    end
  endtask

  // Drive one cycle of inputs, check outputs, then advance the model across the edge
  task automatic applyStimulus(input logic v, input logic [N-1:0] d,
                               input logic mr, input logic fl);
    logic do_push;
    logic do_pop;
    s_valid = v;
    s_data  = v ? d : {$urandom, $urandom};
    m_ready = mr;
    flush   = fl;
    checkModel();
    do_push = v && (model_q.size() < 2);
    do_pop  = mr && (model_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) begin
        void'(model_q.pop_front());
      end
      if (do_push) begin
        model_q.push_back(d);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic streamWords();
    logic [N-1:0] words[5];
    words[0] = 64'd10;
    words[1] = 64'd21;
    words[2] = 64'd41;
    words[3] = 64'd44;
    words[4] = 64'd151375;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, words[i], 1'b1, 1'b0);
      checkOutput("stream_no_bubble", m_data, words[i]);
    end
    drain(2);
  endtask

  initial begin
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    reset   = 1'b0;

    // Reset held for five cycles: everything must read as empty and not ready
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rst_m_valid", N'(m_valid), '0);
      checkOutput("rst_m_data", m_data, '0);
      checkOutput("rst_occupancy", N'(occupancy), '0);
      checkOutput("rst_s_ready", N'(s_ready), '0);
    end
    reset = 1'b1;
    #1;
    checkOutput("release_s_ready", N'(s_ready), N'(1));

    // Streaming with the reader always ready
    streamWords();

    // Backpressure: two words fill the stage, a third is refused
    applyStimulus(1'b1, 64'd999999, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd31, 1'b0, 1'b0);
    checkOutput("bp_occupancy", N'(occupancy), N'(2));
    checkOutput("bp_s_ready", N'(s_ready), '0);
    checkOutput("bp_m_data", m_data, 64'd999999);
    applyStimulus(1'b1, 64'd555, 1'b0, 1'b0);
    checkOutput("bp_hold", m_data, 64'd999999);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_second", m_data, 64'd31);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_empty", N'(occupancy), '0);

    // Simultaneous push and pop while one word is held
    applyStimulus(1'b1, 64'd124124124, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd12121212, 1'b1, 1'b0);
    checkOutput("pp_m_data", m_data, 64'd12121212);
    checkOutput("pp_occupancy", N'(occupancy), N'(1));
    drain(2);

    // Flush while full, with a concurrent push that must be dropped
    applyStimulus(1'b1, 64'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd8, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd9, 1'b0, 1'b1);
    checkOutput("flush_occupancy", N'(occupancy), '0);
    checkOutput("flush_m_valid", N'(m_valid), '0);
    drain(3);

    // Asynchronous reset between edges while full
    applyStimulus(1'b1, 64'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd8, 1'b0, 1'b0);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_m_valid", N'(m_valid), '0);
    checkOutput("midrst_occupancy", N'(occupancy), '0);
    checkOutput("midrst_s_ready", N'(s_ready), '0);
    checkOutput("midrst_m_data", m_data, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_q.delete();
    #1;
    checkOutput("midrst_release_s_ready", N'(s_ready), N'(1));
    streamWords();

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, {$urandom, $urandom},
                    $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    end
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
